// File: rtl/config_chain_loader_if.sv
// Host/chain-side bundle for config_chain_loader: the config word stream,
// the chain shift pins, the readback words and the load status flags.
interface config_chain_loader_if #(
  parameter int WORD_WIDTH = 8
);
  logic                  start;
  logic                  in_valid;
  logic                  in_ready;
  logic [WORD_WIDTH-1:0] in_data;
  logic                  chain_shift_enable;
  logic                  chain_shift_in;
  logic                  chain_shift_out;
  logic                  rb_valid;
  logic [WORD_WIDTH-1:0] rb_data;
  logic                  busy;
  logic                  done;

  modport master (
    output start, in_valid, in_data, chain_shift_out,
    input  in_ready, chain_shift_enable, chain_shift_in, rb_valid, rb_data, busy, done
  );

  modport slave (
    input  start, in_valid, in_data, chain_shift_out,
    output in_ready, chain_shift_enable, chain_shift_in, rb_valid, rb_data, busy, done
  );
endinterface

// File: rtl/config_chain_loader.sv
// Serialises config words LSB-first into a CHAIN_LENGTH-bit shift chain while
// capturing the chain's tail bit, returning the previous contents as readback words.
module config_chain_loader #(
  parameter int CHAIN_LENGTH = 8,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  config_chain_loader_if.slave  bus
);
  localparam int RW = $clog2(CHAIN_LENGTH + 1);
  localparam int BW = $clog2(WORD_WIDTH + 1);
  localparam int IW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                state_q;
  logic [WORD_WIDTH-1:0] word_q;
  logic [WORD_WIDTH-1:0] rb_q;
  logic [IW-1:0]         rb_idx_q;
  logic [RW-1:0]         remaining_q;
  logic [BW-1:0]         word_bits_q;
  logic                  rb_valid_q;
  logic [WORD_WIDTH-1:0] rb_data_q;

  logic [BW-1:0]         word_bits_d;
  logic [WORD_WIDTH-1:0] rb_sample_d;

  // The last word of a load only carries the bits still owed to the chain.
  always_comb begin
    if (32'(remaining_q) >= WORD_WIDTH) word_bits_d = BW'(WORD_WIDTH);
    else                                 word_bits_d = BW'(remaining_q);
  end

  // Readback including the tail bit captured on the upcoming shift edge.
  always_comb begin
    rb_sample_d           = rb_q;
    rb_sample_d[rb_idx_q] = bus.chain_shift_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      word_q      <= '0;
      rb_q        <= '0;
      rb_idx_q    <= '0;
      remaining_q <= '0;
      word_bits_q <= '0;
      rb_valid_q  <= 1'b0;
      rb_data_q   <= '0;
    end else begin
      rb_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            remaining_q <= RW'(CHAIN_LENGTH);
            state_q     <= LOAD;
          end
        end
        LOAD: begin
          if (bus.in_valid) begin
            word_q      <= bus.in_data;
            word_bits_q <= word_bits_d;
            rb_q        <= '0;
            rb_idx_q    <= '0;
            state_q     <= SHIFT;
          end
        end
        SHIFT: begin
          word_q      <= word_q >> 1;
          rb_q        <= rb_sample_d;
          rb_idx_q    <= rb_idx_q + IW'(1);
          remaining_q <= remaining_q - RW'(1);
          word_bits_q <= word_bits_q - BW'(1);
          if (word_bits_q == BW'(1)) begin
            rb_valid_q <= 1'b1;
            rb_data_q  <= rb_sample_d;
            state_q    <= (remaining_q == RW'(1)) ? DONE : LOAD;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy               = (state_q != IDLE);
  assign bus.in_ready           = (state_q == LOAD);
  assign bus.chain_shift_enable = (state_q == SHIFT);
  assign bus.chain_shift_in     = (state_q == SHIFT) & word_q[0];
  assign bus.done               = (state_q == DONE);
  assign bus.rb_valid           = rb_valid_q;
  assign bus.rb_data            = rb_data_q;
endmodule

// File: tb/tb_config_chain_loader.sv
module tb_config_chain_loader;
  logic clk;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  config_chain_loader_if #(.WORD_WIDTH(8)) ifa ();
  config_chain_loader_if #(.WORD_WIDTH(4)) ifb ();

  config_chain_loader #(.CHAIN_LENGTH(8), .WORD_WIDTH(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  config_chain_loader #(.CHAIN_LENGTH(10), .WORD_WIDTH(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_chk++;
    n_fail++;
    $error("FAIL %s", tag);
  endtask

  logic [7:0] chain_a = '0;
  logic [9:0] chain_b = '0;
  always @(posedge clk) if (ifa.chain_shift_enable) chain_a <= {chain_a[6:0], ifa.chain_shift_in};
  always @(posedge clk) if (ifb.chain_shift_enable) chain_b <= {chain_b[8:0], ifb.chain_shift_in};
  assign ifa.chain_shift_out = chain_a[7];
  assign ifb.chain_shift_out = chain_b[9];

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int sh_a = 0, sh_b = 0, dn_a = 0, dn_b = 0;
  logic pd_a = 1'b0, pd_b = 1'b0;

  always @(negedge clk) begin
    if (ifa.chain_shift_enable) sh_a++;
    if (ifa.done) begin
      dn_a++;
      n_chk++;
      if (ifa.rb_valid !== 1'b1) begin
        n_fail++;
        $error("FAIL a_done_with_rb_valid observed=%0h expected=1", ifa.rb_valid);
      end
    end
    if (pd_a) begin
      n_chk++;
      if (ifa.busy !== 1'b0) begin
        n_fail++;
        $error("FAIL a_busy_after_done observed=%0h expected=0", ifa.busy);
      end
    end
    pd_a = ifa.done;
    if (ifa.rb_valid) begin
      if (exp_a.size() == 0) fail_now("a_rb_unexpected");
      else begin
        logic [7:0] e;
        e = exp_a.pop_front();
        n_chk++;
        if (ifa.rb_data !== e) begin
          n_fail++;
          $error("FAIL a_rb_data observed=%0h expected=%0h", ifa.rb_data, e);
        end
        $display("a readback word %02h (expected %02h)", ifa.rb_data, e);
      end
    end
  end

  always @(negedge clk) begin
    if (ifb.chain_shift_enable) sh_b++;
    if (ifb.done) begin
      dn_b++;
      n_chk++;
      if (ifb.rb_valid !== 1'b1) begin
        n_fail++;
        $error("FAIL b_done_with_rb_valid observed=%0h expected=1", ifb.rb_valid);
      end
    end
    if (pd_b) begin
      n_chk++;
      if (ifb.busy !== 1'b0) begin
        n_fail++;
        $error("FAIL b_busy_after_done observed=%0h expected=0", ifb.busy);
      end
    end
    pd_b = ifb.done;
    if (ifb.rb_valid) begin
      if (exp_b.size() == 0) fail_now("b_rb_unexpected");
      else begin
        logic [7:0] e;
        e = exp_b.pop_front();
        n_chk++;
        if ({4'b0, ifb.rb_data} !== e) begin
          n_fail++;
          $error("FAIL b_rb_data observed=%0h expected=%0h", ifb.rb_data, e);
        end
        $display("b readback word %01h (expected %01h)", ifb.rb_data, e[3:0]);
      end
    end
  end

  function automatic logic rdy(input bit sel);
    return sel ? ifb.in_ready : ifa.in_ready;
  endfunction
  function automatic logic shen(input bit sel);
    return sel ? ifb.chain_shift_enable : ifa.chain_shift_enable;
  endfunction
  function automatic logic bsy(input bit sel);
    return sel ? ifb.busy : ifa.busy;
  endfunction
  function automatic logic dne(input bit sel);
    return sel ? ifb.done : ifa.done;
  endfunction

  task automatic drive_start(input bit sel, input logic v);
    if (sel) ifb.start = v; else ifa.start = v;
  endtask
  task automatic drive_in(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin ifb.in_valid = v; ifb.in_data = d[3:0]; end
    else     begin ifa.in_valid = v; ifa.in_data = d; end
  endtask

  task automatic do_load(input bit sel, input logic [7:0] w0, input logic [7:0] w1,
                         input logic [7:0] w2, input int stall, input bit poke);
    int L, W, nw, sh0, dn0, guard;
    logic [31:0] prior, fin;
    logic [7:0] wd[3];
    logic [7:0] rbw;
    L = sel ? 10 : 8;
    W = sel ? 4 : 8;
    nw = (L + W - 1) / W;
    wd[0] = w0; wd[1] = w1; wd[2] = w2;
    prior = sel ? 32'(chain_b) : 32'(chain_a);
    fin = '0;
    for (int j = 0; j < nw; j++) begin
      rbw = '0;
      for (int b = 0; b < W; b++) begin
        int k;
        k = j * W + b;
        if (k < L) begin
          rbw[b] = prior[L-1-k];
          fin[L-1-k] = wd[j][b];
        end
      end
      if (sel) exp_b.push_back(rbw); else exp_a.push_back(rbw);
    end
    sh0 = sel ? sh_b : sh_a;
    dn0 = sel ? dn_b : dn_a;
    @(negedge clk) drive_start(sel, 1'b1);
    @(negedge clk) drive_start(sel, 1'b0);
    for (int j = 0; j < nw; j++) begin
      guard = 0;
      while (!rdy(sel) && guard < 50) begin @(negedge clk); guard++; end
      chk("in_ready_wait", rdy(sel), 1'b1);
      if (j > 0) begin
        for (int s = 0; s < stall; s++) begin
          chk("stall_in_ready", rdy(sel), 1'b1);
          chk("stall_shift_enable", shen(sel), 1'b0);
          @(negedge clk);
        end
      end
      drive_in(sel, 1'b1, wd[j]);
      @(negedge clk) drive_in(sel, 1'b0, 8'h00);
      if (poke && j == nw - 1) begin
        drive_start(sel, 1'b1);
        @(negedge clk) drive_start(sel, 1'b0);
      end
    end
    if (poke) begin
      guard = 0;
      while (!dne(sel) && guard < 50) begin @(negedge clk); guard++; end
      chk("done_wait", dne(sel), 1'b1);
      drive_start(sel, 1'b1);
      @(negedge clk) drive_start(sel, 1'b0);
    end
    guard = 0;
    while (bsy(sel) && guard < 50) begin @(negedge clk); guard++; end
    repeat (3) @(negedge clk);
    chk("idle_after_load", bsy(sel), 1'b0);
    chk("shift_count", (sel ? sh_b : sh_a) - sh0, L);
    chk("done_count", (sel ? dn_b : dn_a) - dn0, 1);
    chk("chain_content", sel ? 32'(chain_b) : 32'(chain_a), fin);
    chk("rb_words_pending", sel ? exp_b.size() : exp_a.size(), 0);
    $display("load on %s: words %h %h %h stall=%0d -> chain %h", sel ? "b" : "a",
             w0, w1, w2, stall, sel ? 32'(chain_b) : 32'(chain_a));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] part;
    int guard, seen;
    rst = 1'b1;
    ifa.start = 1'b0; ifa.in_valid = 1'b0; ifa.in_data = '0;
    ifb.start = 1'b0; ifb.in_valid = 1'b0; ifb.in_data = '0;
    repeat (2) @(negedge clk);
    chk("reset_a_busy", ifa.busy, 1'b0);
    chk("reset_a_in_ready", ifa.in_ready, 1'b0);
    chk("reset_a_shift_enable", ifa.chain_shift_enable, 1'b0);
    chk("reset_a_shift_in", ifa.chain_shift_in, 1'b0);
    chk("reset_a_rb", {ifa.rb_valid, ifa.rb_data}, 9'h000);
    chk("reset_b_flags", {ifb.busy, ifb.in_ready, ifb.done, ifb.rb_valid}, 4'h0);
    $display("reset state checked");
    rst = 1'b0;
    @(negedge clk);

    do_load(1'b0, 8'h01, 8'h00, 8'h00, 0, 1'b0);
    do_load(1'b0, 8'h3C, 8'h00, 8'h00, 0, 1'b0);
    do_load(1'b0, 8'h00, 8'h00, 8'h00, 0, 1'b0);
    do_load(1'b1, 8'h0F, 8'h00, 8'h03, 0, 1'b0);
    do_load(1'b1, 8'h0F, 8'h00, 8'h03, 5, 1'b0);
    do_load(1'b1, 8'h0A, 8'h05, 8'h0E, 0, 1'b1);
    do_load(1'b0, 8'hA5, 8'h00, 8'h00, 0, 1'b1);

    part = {chain_a[4:0], 3'b111};
    @(negedge clk) ifa.start = 1'b1;
    @(negedge clk) ifa.start = 1'b0;
    guard = 0;
    while (!ifa.in_ready && guard < 50) begin @(negedge clk); guard++; end
    ifa.in_valid = 1'b1; ifa.in_data = 8'hFF;
    @(negedge clk) ifa.in_valid = 1'b0;
    seen = 0; guard = 0;
    while (seen < 3 && guard < 50) begin
      if (ifa.chain_shift_enable) seen++;
      if (seen < 3) @(negedge clk);
      guard++;
    end
    chk("mid_shift_reached", seen, 3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_shift_enable", ifa.chain_shift_enable, 1'b0);
    chk("async_rst_busy", ifa.busy, 1'b0);
    chk("async_rst_in_ready", ifa.in_ready, 1'b0);
    chk("async_rst_rb_valid", ifa.rb_valid, 1'b0);
    chk("async_rst_done", ifa.done, 1'b0);
    repeat (3) @(negedge clk);
    chk("partial_chain", chain_a, part);
    $display("reset mid-shift: chain holds %02h", chain_a);
    exp_a.delete();
    rst = 1'b0;
    @(negedge clk);
    do_load(1'b0, 8'h5A, 8'h00, 8'h00, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/config_chain_loader.md
Name: config_chain_loader

Overview:
- Host-side driver for the configuration shift chain: accepts config words over a valid/ready stream and serialises them bit-by-bit into the chain's shift input under shift-enable control.
- Simultaneously samples the chain's serial output, returning the chain's previous contents as readback words.
- Sits between the config host (bitstream DMA / scan controller) and the head of a chain of CHAIN_LENGTH shift bits.

Parameters:
- CHAIN_LENGTH, 8, total chain bits to shift per load; must be >= 1.
- WORD_WIDTH, 8, width of the in/readback words; must be >= 1.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  pulse in IDLE begins a load of CHAIN_LENGTH bits; ignored when busy=1.
- in_valid  input  1  config word available.
- in_ready  output  1  loader accepts in_data this cycle.
- in_data  input  WORD_WIDTH  config word; bits shifted LSB first.
- chain_shift_enable  output  1  drives the chain's shift_enable.
- chain_shift_in  output  1  drives the chain's shift_in (head bit).
- chain_shift_out  input  1  the chain's shift_out (tail bit).
- rb_valid  output  1  one-cycle pulse: rb_data holds a readback word (no backpressure).
- rb_data  output  WORD_WIDTH  readback bits, LSB = first sampled.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a load completes.

Behaviour:
- Reset (async, any state, including mid-shift): state=IDLE; all outputs 0; word/readback registers, bit counters cleared. chain_shift_enable drops immediately, so the chain stops shifting (it is left partially loaded).
- FSM IDLE -> LOAD -> SHIFT -> (LOAD | DONE) -> IDLE; state, data and counters registered; outputs decoded from registered state.
- IDLE: busy=0. If start=1, set remaining=CHAIN_LENGTH, go LOAD.
- LOAD: in_ready=1. On in_valid&in_ready:
  - word_reg<=in_data; word_bits<=min(WORD_WIDTH, remaining); rb_reg<=0; rb_idx<=0.
  - Go SHIFT.
  - No in_valid: stay in LOAD indefinitely.
- SHIFT, each cycle:
  - chain_shift_enable=1; chain_shift_in=word_reg[0].
  - word_reg shifts right by 1.
  - rb_reg[rb_idx]<=chain_shift_out, sampled in the same cycle as the shift edge; rb_idx++.
  - remaining--; word_bits--.
  - When word_bits reaches 0 after this cycle:
    - Next cycle, rb_valid=1 and rb_data=rb_reg; unused upper bits of a partial last word read 0.
    - Go LOAD if remaining>0, else DONE.
- DONE: done=1 for one cycle, busy=1; rb_valid for the final word coincides with this cycle; next state IDLE.
- Bit order:
  - Bit k of the overall stream (k=0 first) ends at chain config_data[CHAIN_LENGTH-1-k].
  - Readback bit k equals the chain's prior config_data[CHAIN_LENGTH-1-k].
  - Consequence: loading stream S, then any stream T, returns S in readback.
- Word count per load: ceil(CHAIN_LENGTH/WORD_WIDTH). The last word uses only its low (CHAIN_LENGTH mod WORD_WIDTH, or WORD_WIDTH if 0) bits; its upper bits are discarded.
- chain_shift_enable is high for exactly CHAIN_LENGTH cycles per load, never in IDLE/LOAD/DONE.
- Throughput: one LOAD cycle minimum between words (shifting pauses while waiting for in_valid); a word of W bits costs W+1 cycles best case.
- start while busy: ignored. in_valid outside LOAD: not accepted (in_ready=0), data held by host.
- Counters sized $clog2(CHAIN_LENGTH+1) and $clog2(WORD_WIDTH+1); no wrap within a load.

Test Plan:
- Reset values: assert rst mid-SHIFT of a 0xFF load -> same-cycle chain_shift_enable=0, busy=0, in_ready=0, rb_valid=0, done=0; chain retains partial content; subsequent start works normally.
- L=8,W=8, chain initially 0: start, word 0x01 -> chain_shift_enable high 8 consecutive cycles, chain config_data=0x80, rb_data=0x00 with rb_valid, done one cycle later/concurrent with rb_valid per FSM, busy falls next cycle.
- Readback round-trip, L=8,W=8: load 0x3C then load 0x00 -> second load's rb_data=0x3C; chain config_data=0x00.
- Partial word, L=10,W=4: words 0xF,0x0,0x3 -> exactly 10 shift cycles; third word uses 2 bits; chain config_data=0b1111000011 reversed-order check (config_data[9:6]=1111, [5:2]=0000, [1:0]=11); three rb_valid pulses, third rb_data upper 2 bits = 0.
- Backpressure: hold in_valid=0 for 5 cycles in LOAD between words -> chain_shift_enable low throughout, in_ready stays 1, no bits lost; final config identical to the no-stall run.
- start pulsed during SHIFT and DONE -> ignored; exactly one done pulse and CHAIN_LENGTH shifts per load.
